// File: rtl/reorder_buffer_pkg.sv
// Shared widths, the no-exception code and the ROB entry layout.
package reorder_buffer_pkg;
  localparam int ROB_DEPTH  = 16;
  localparam int ROB_ADDR_W = $clog2(ROB_DEPTH);
  localparam int GHR_W      = 5;
  localparam int CP0_ADDR_W = 8;
  localparam int EXC_W      = 8;
  localparam int OPGEN_W    = 6;
  localparam int SHAMT_W    = 5;
  localparam int DATA_W     = 32;
  localparam int REG_W      = 5;

  localparam logic [EXC_W-1:0] NO_EXC = '0;

  typedef struct packed {
    logic                  reg_write_en;
    logic [REG_W-1:0]      reg_write_addr;
    logic [DATA_W-1:0]     reg_write_data;
    logic                  is_delayslot;
    logic [DATA_W-1:0]     pc;
    logic                  is_branch_taken;
    logic [GHR_W-1:0]      pht_index;
    logic [DATA_W-1:0]     inst_branch_target;
    logic                  mem_write_flag;
    logic                  mem_read_flag;
    logic                  mem_sign_ext_flag;
    logic [3:0]            mem_sel;
    logic [DATA_W-1:0]     mem_offset;
    logic                  cp0_read_flag;
    logic                  cp0_write_flag;
    logic [CP0_ADDR_W-1:0] cp0_addr;
    logic [EXC_W-1:0]      exception_type;
    logic [OPGEN_W-1:0]    opgen;
    logic [SHAMT_W-1:0]    shamt;
    logic                  operand_is_ref_1;
    logic                  operand_is_ref_2;
    logic [DATA_W-1:0]     operand_data_1;
    logic [DATA_W-1:0]     operand_data_2;
  } rob_entry_t;
endpackage

// File: rtl/reorder_buffer_if.sv
// ROB port bundle: decode write, issue read, execute update, commit and erase.
interface reorder_buffer_if;
  import reorder_buffer_pkg::*;

  // issue read side
  logic read_en, can_read;
  logic [ROB_ADDR_W-1:0] read_rob_addr_out;
  logic [DATA_W-1:0] read_pc_out, read_inst_branch_target_out, read_mem_offset_out;
  logic read_is_branch_taken_out;
  logic [GHR_W-1:0] read_pht_index_out;
  logic read_mem_write_flag_out, read_mem_read_flag_out, read_mem_sign_ext_flag_out;
  logic [3:0] read_mem_sel_out;
  logic read_cp0_read_flag_out, read_cp0_write_flag_out;
  logic [CP0_ADDR_W-1:0] read_cp0_addr_out;
  logic [EXC_W-1:0] read_exception_type_out;
  logic [OPGEN_W-1:0] read_opgen_out;
  logic [SHAMT_W-1:0] read_shamt_out;
  logic read_operand_is_ref_1_out, read_operand_is_ref_2_out;
  logic [DATA_W-1:0] read_operand_data_1_out, read_operand_data_2_out;

  // decode write side
  logic write_en, can_write;
  logic [ROB_ADDR_W-1:0] write_rob_addr_out;
  logic write_reg_write_en_in, write_is_delayslot_in;
  logic [REG_W-1:0] write_reg_write_addr_in;
  logic [DATA_W-1:0] write_pc_in, write_inst_branch_target_in, write_mem_offset_in;
  logic write_is_branch_taken_in;
  logic [GHR_W-1:0] write_pht_index_in;
  logic write_mem_write_flag_in, write_mem_read_flag_in, write_mem_sign_ext_flag_in;
  logic [3:0] write_mem_sel_in;
  logic write_cp0_read_flag_in, write_cp0_write_flag_in;
  logic [CP0_ADDR_W-1:0] write_cp0_addr_in;
  logic [EXC_W-1:0] write_exception_type_in;
  logic [OPGEN_W-1:0] write_opgen_in;
  logic [SHAMT_W-1:0] write_shamt_in;
  logic write_operand_is_ref_1_in, write_operand_is_ref_2_in;
  logic [DATA_W-1:0] write_operand_data_1_in, write_operand_data_2_in;

  // execute update
  logic update_en;
  logic [ROB_ADDR_W-1:0] update_addr;
  logic [DATA_W-1:0] update_reg_write_data_in;
  logic [EXC_W-1:0] update_exception_type_in;

  // commit
  logic commit_en, can_commit;
  logic commit_reg_write_en_out, commit_is_delayslot_out;
  logic [REG_W-1:0] commit_reg_write_addr_out;
  logic [DATA_W-1:0] commit_reg_write_data_out, commit_pc_out;
  logic [EXC_W-1:0] commit_exception_type_out;

  // branch recovery
  logic erase_en;
  logic [ROB_ADDR_W-1:0] erase_from_addr;

  modport master (
    output read_en, write_en, write_reg_write_en_in, write_is_delayslot_in, write_reg_write_addr_in,
           write_pc_in, write_inst_branch_target_in, write_mem_offset_in, write_is_branch_taken_in,
           write_pht_index_in, write_mem_write_flag_in, write_mem_read_flag_in, write_mem_sign_ext_flag_in,
           write_mem_sel_in, write_cp0_read_flag_in, write_cp0_write_flag_in, write_cp0_addr_in,
           write_exception_type_in, write_opgen_in, write_shamt_in, write_operand_is_ref_1_in,
           write_operand_is_ref_2_in, write_operand_data_1_in, write_operand_data_2_in,
           update_en, update_addr, update_reg_write_data_in, update_exception_type_in,
           commit_en, erase_en, erase_from_addr,
    input  can_read, read_rob_addr_out, read_pc_out, read_inst_branch_target_out, read_mem_offset_out,
           read_is_branch_taken_out, read_pht_index_out, read_mem_write_flag_out, read_mem_read_flag_out,
           read_mem_sign_ext_flag_out, read_mem_sel_out, read_cp0_read_flag_out, read_cp0_write_flag_out,
           read_cp0_addr_out, read_exception_type_out, read_opgen_out, read_shamt_out,
           read_operand_is_ref_1_out, read_operand_is_ref_2_out, read_operand_data_1_out,
           read_operand_data_2_out, can_write, write_rob_addr_out, can_commit,
           commit_reg_write_en_out, commit_is_delayslot_out, commit_reg_write_addr_out,
           commit_reg_write_data_out, commit_pc_out, commit_exception_type_out
  );

  modport slave (
    input  read_en, write_en, write_reg_write_en_in, write_is_delayslot_in, write_reg_write_addr_in,
           write_pc_in, write_inst_branch_target_in, write_mem_offset_in, write_is_branch_taken_in,
           write_pht_index_in, write_mem_write_flag_in, write_mem_read_flag_in, write_mem_sign_ext_flag_in,
           write_mem_sel_in, write_cp0_read_flag_in, write_cp0_write_flag_in, write_cp0_addr_in,
           write_exception_type_in, write_opgen_in, write_shamt_in, write_operand_is_ref_1_in,
           write_operand_is_ref_2_in, write_operand_data_1_in, write_operand_data_2_in,
           update_en, update_addr, update_reg_write_data_in, update_exception_type_in,
           commit_en, erase_en, erase_from_addr,
    output can_read, read_rob_addr_out, read_pc_out, read_inst_branch_target_out, read_mem_offset_out,
           read_is_branch_taken_out, read_pht_index_out, read_mem_write_flag_out, read_mem_read_flag_out,
           read_mem_sign_ext_flag_out, read_mem_sel_out, read_cp0_read_flag_out, read_cp0_write_flag_out,
           read_cp0_addr_out, read_exception_type_out, read_opgen_out, read_shamt_out,
           read_operand_is_ref_1_out, read_operand_is_ref_2_out, read_operand_data_1_out,
           read_operand_data_2_out, can_write, write_rob_addr_out, can_commit,
           commit_reg_write_en_out, commit_is_delayslot_out, commit_reg_write_addr_out,
           commit_reg_write_data_out, commit_pc_out, commit_exception_type_out
  );
endinterface

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: tail allocate, once-only issue read,
// by-address completion update, head commit and tail erase for branch recovery.
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input logic clk,
  input logic rst,
  reorder_buffer_if.slave bus
);
  localparam logic [ROB_ADDR_W:0] FULL = (ROB_ADDR_W+1)'(ROB_DEPTH);

  rob_entry_t            r_ent [ROB_DEPTH];
  logic [ROB_DEPTH-1:0]  r_done;
  logic [ROB_ADDR_W-1:0] r_head, r_tail, r_rd;
  // r_count: live entries head..tail; r_unread: live entries not yet issued (rd..tail)
  logic [ROB_ADDR_W:0]   r_count, r_unread;

  logic [ROB_ADDR_W-1:0] w_head_n, w_tail_n, w_rd_n, w_ofs;
  logic [ROB_ADDR_W:0]   w_cnt_n, w_unread_n, w_consumed;
  logic w_can_write, w_can_read, w_can_commit;
  logic w_erase_hit, w_cmt, w_wr, w_rd, w_upd;
  rob_entry_t w_wr_ent, w_rd_ent, w_cm_ent;

  assign w_can_write  = (r_count != FULL);
  assign w_can_read   = (r_unread != '0);
  assign w_can_commit = (r_count != '0) && r_done[r_head];
  assign w_consumed   = r_count - r_unread;

  // Erase only acts when the address is a live entry; any erase request blocks
  // write/read/update, while a commit survives unless it is the erased head.
  assign w_ofs       = bus.erase_from_addr - r_head;
  assign w_erase_hit = bus.erase_en && ({1'b0, w_ofs} < r_count);
  assign w_cmt = bus.commit_en && w_can_commit && !(w_erase_hit && (w_ofs == '0));
  assign w_wr  = !bus.erase_en && bus.write_en && (w_can_write || w_cmt);
  assign w_rd  = !bus.erase_en && bus.read_en && w_can_read;
  assign w_upd = !bus.erase_en && bus.update_en;

  assign w_wr_ent = '{
    reg_write_en: bus.write_reg_write_en_in, reg_write_addr: bus.write_reg_write_addr_in,
    reg_write_data: '0, is_delayslot: bus.write_is_delayslot_in, pc: bus.write_pc_in,
    is_branch_taken: bus.write_is_branch_taken_in, pht_index: bus.write_pht_index_in,
    inst_branch_target: bus.write_inst_branch_target_in,
    mem_write_flag: bus.write_mem_write_flag_in, mem_read_flag: bus.write_mem_read_flag_in,
    mem_sign_ext_flag: bus.write_mem_sign_ext_flag_in, mem_sel: bus.write_mem_sel_in,
    mem_offset: bus.write_mem_offset_in, cp0_read_flag: bus.write_cp0_read_flag_in,
    cp0_write_flag: bus.write_cp0_write_flag_in, cp0_addr: bus.write_cp0_addr_in,
    exception_type: bus.write_exception_type_in, opgen: bus.write_opgen_in,
    shamt: bus.write_shamt_in, operand_is_ref_1: bus.write_operand_is_ref_1_in,
    operand_is_ref_2: bus.write_operand_is_ref_2_in,
    operand_data_1: bus.write_operand_data_1_in, operand_data_2: bus.write_operand_data_2_in};

  // Pointer/counter next state: erase truncation first, then read, write, commit.
  always_comb begin
    w_head_n   = r_head;
    w_tail_n   = r_tail;
    w_rd_n     = r_rd;
    w_cnt_n    = r_count;
    w_unread_n = r_unread;
    if (w_erase_hit) begin
      w_tail_n = bus.erase_from_addr;
      w_cnt_n  = {1'b0, w_ofs};
      if (w_consumed > {1'b0, w_ofs}) begin
        w_rd_n     = bus.erase_from_addr;
        w_unread_n = '0;
      end else begin
        w_unread_n = {1'b0, w_ofs} - w_consumed;
      end
    end
    if (w_rd) begin
      w_rd_n     = w_rd_n + 1'b1;
      w_unread_n = w_unread_n - 1'b1;
    end
    if (w_wr) begin
      w_tail_n   = w_tail_n + 1'b1;
      w_cnt_n    = w_cnt_n + 1'b1;
      w_unread_n = w_unread_n + 1'b1;
    end
    if (w_cmt) begin
      // retiring a never-issued head drags the read pointer along with it
      if (w_cnt_n == w_unread_n) begin
        w_rd_n     = w_rd_n + 1'b1;
        w_unread_n = w_unread_n - 1'b1;
      end
      w_head_n = w_head_n + 1'b1;
      w_cnt_n  = w_cnt_n - 1'b1;
    end
  end

  // Pointer and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head   <= '0;
      r_tail   <= '0;
      r_rd     <= '0;
      r_count  <= '0;
      r_unread <= '0;
    end else begin
      r_head   <= w_head_n;
      r_tail   <= w_tail_n;
      r_rd     <= w_rd_n;
      r_count  <= w_cnt_n;
      r_unread <= w_unread_n;
    end
  end

  // Entry storage; a write to the slot being updated in the same cycle wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ROB_DEPTH; i++) r_ent[i] <= '0;
      r_done <= '0;
    end else begin
      if (w_upd) begin
        r_ent[bus.update_addr].reg_write_data <= bus.update_reg_write_data_in;
        r_ent[bus.update_addr].exception_type <= bus.update_exception_type_in;
        r_done[bus.update_addr] <= 1'b1;
      end
      if (w_wr) begin
        r_ent[r_tail]  <= w_wr_ent;
        r_done[r_tail] <= 1'b0;
      end
    end
  end

  assign w_rd_ent = r_ent[r_rd];
  assign w_cm_ent = r_ent[r_head];

  assign bus.can_write          = w_can_write;
  assign bus.can_read           = w_can_read;
  assign bus.can_commit         = w_can_commit;
  assign bus.write_rob_addr_out = r_tail;
  assign bus.read_rob_addr_out  = r_rd;

  assign bus.read_pc_out                 = w_rd_ent.pc;
  assign bus.read_is_branch_taken_out    = w_rd_ent.is_branch_taken;
  assign bus.read_pht_index_out          = w_rd_ent.pht_index;
  assign bus.read_inst_branch_target_out = w_rd_ent.inst_branch_target;
  assign bus.read_mem_write_flag_out     = w_rd_ent.mem_write_flag;
  assign bus.read_mem_read_flag_out      = w_rd_ent.mem_read_flag;
  assign bus.read_mem_sign_ext_flag_out  = w_rd_ent.mem_sign_ext_flag;
  assign bus.read_mem_sel_out            = w_rd_ent.mem_sel;
  assign bus.read_mem_offset_out         = w_rd_ent.mem_offset;
  assign bus.read_cp0_read_flag_out      = w_rd_ent.cp0_read_flag;
  assign bus.read_cp0_write_flag_out     = w_rd_ent.cp0_write_flag;
  assign bus.read_cp0_addr_out           = w_rd_ent.cp0_addr;
  assign bus.read_exception_type_out     = w_rd_ent.exception_type;
  assign bus.read_opgen_out              = w_rd_ent.opgen;
  assign bus.read_shamt_out              = w_rd_ent.shamt;
  assign bus.read_operand_is_ref_1_out   = w_rd_ent.operand_is_ref_1;
  assign bus.read_operand_is_ref_2_out   = w_rd_ent.operand_is_ref_2;
  assign bus.read_operand_data_1_out     = w_rd_ent.operand_data_1;
  assign bus.read_operand_data_2_out     = w_rd_ent.operand_data_2;

  assign bus.commit_reg_write_en_out   = w_cm_ent.reg_write_en;
  assign bus.commit_reg_write_addr_out = w_cm_ent.reg_write_addr;
  assign bus.commit_reg_write_data_out = w_cm_ent.reg_write_data;
  assign bus.commit_exception_type_out = w_cm_ent.exception_type;
  assign bus.commit_is_delayslot_out   = w_cm_ent.is_delayslot;
  assign bus.commit_pc_out             = w_cm_ent.pc;
endmodule

// File: tb/tb_reorder_buffer.sv
// Directed scenario followed by randomized traffic against a queue-based ROB model.
module tb_reorder_buffer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  reorder_buffer_if bus();

  reorder_buffer dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] pc;
    logic [5:0]  opg;
    logic [31:0] op1;
    logic [7:0]  exc;
    logic [31:0] data;
    logic        rwe;
    logic [4:0]  rwa;
    logic        ds;
    bit          done;
  } ment_t;

  ment_t q[$];
  int rdn = 0;    // entries from the head already issued
  int mhead = 0;  // ROB address of q[0]
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    bus.read_en = 0; bus.write_en = 0; bus.update_en = 0; bus.commit_en = 0; bus.erase_en = 0;
    bus.update_addr = 0; bus.erase_from_addr = 0;
    bus.update_reg_write_data_in = 0; bus.update_exception_type_in = 0;
  endtask

  task automatic set_write(input logic [31:0] pc);
    bus.write_en = 1;
    bus.write_pc_in = pc;
    bus.write_reg_write_en_in = 1'($urandom);
    bus.write_reg_write_addr_in = 5'($urandom);
    bus.write_is_delayslot_in = 1'($urandom);
    bus.write_opgen_in = 6'($urandom);
    bus.write_operand_data_1_in = $urandom;
    bus.write_operand_data_2_in = $urandom;
    bus.write_exception_type_in = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
    bus.write_inst_branch_target_in = $urandom;
    bus.write_mem_offset_in = $urandom;
    bus.write_is_branch_taken_in = 1'($urandom);
    bus.write_pht_index_in = 5'($urandom);
    bus.write_mem_write_flag_in = 1'($urandom);
    bus.write_mem_read_flag_in = 1'($urandom);
    bus.write_mem_sign_ext_flag_in = 1'($urandom);
    bus.write_mem_sel_in = 4'($urandom);
    bus.write_cp0_read_flag_in = 1'($urandom);
    bus.write_cp0_write_flag_in = 1'($urandom);
    bus.write_cp0_addr_in = 8'($urandom);
    bus.write_shamt_in = 5'($urandom);
    bus.write_operand_is_ref_1_in = 1'($urandom);
    bus.write_operand_is_ref_2_in = 1'($urandom);
  endtask

  task automatic set_update(input logic [3:0] a);
    bus.update_en = 1;
    bus.update_addr = a;
    bus.update_reg_write_data_in = $urandom;
    bus.update_exception_type_in = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    int n;
    int ofs;
    bit cw, cc, hit, cmt, wr, rd, upd;
    ment_t e;
    if (rst) begin
      q.delete(); rdn = 0; mhead = 0;
      return;
    end
    n   = q.size();
    cw  = (n != 16);
    cc  = (n != 0) && q[0].done;
    ofs = (int'(bus.erase_from_addr) - mhead) & 15;
    hit = bus.erase_en && (ofs < n);
    cmt = bus.commit_en && cc && !(hit && ofs == 0);
    wr  = !bus.erase_en && bus.write_en && (cw || cmt);
    rd  = !bus.erase_en && bus.read_en && (rdn < n);
    upd = !bus.erase_en && bus.update_en;
    if (hit) begin
      while (q.size() > ofs) void'(q.pop_back());
      if (rdn > ofs) rdn = ofs;
    end
    if (upd)
      foreach (q[i])
        if (q[i].addr == bus.update_addr) begin
          q[i].data = bus.update_reg_write_data_in;
          q[i].exc  = bus.update_exception_type_in;
          q[i].done = 1;
        end
    if (rd) rdn++;
    if (wr) begin
      e.addr = 4'((mhead + q.size()) & 15);
      e.pc = bus.write_pc_in; e.opg = bus.write_opgen_in; e.op1 = bus.write_operand_data_1_in;
      e.exc = bus.write_exception_type_in; e.data = 0; e.rwe = bus.write_reg_write_en_in;
      e.rwa = bus.write_reg_write_addr_in; e.ds = bus.write_is_delayslot_in; e.done = 0;
      q.push_back(e);
    end
    if (cmt) begin
      void'(q.pop_front());
      mhead = (mhead + 1) & 15;
      if (rdn > 0) rdn--;
    end
  endtask

  task automatic check_all();
    int n = q.size();
    chk("can_write", 32'(bus.can_write), 32'(n != 16));
    chk("can_read", 32'(bus.can_read), 32'(rdn < n));
    chk("can_commit", 32'(bus.can_commit), 32'((n != 0) && q[0].done));
    chk("write_rob_addr", 32'(bus.write_rob_addr_out), 32'((mhead + n) & 15));
    if (rdn < n) begin
      chk("read_rob_addr", 32'(bus.read_rob_addr_out), 32'((mhead + rdn) & 15));
      chk("read_pc", bus.read_pc_out, q[rdn].pc);
      chk("read_opgen", 32'(bus.read_opgen_out), 32'(q[rdn].opg));
      chk("read_op1", bus.read_operand_data_1_out, q[rdn].op1);
      chk("read_exc", 32'(bus.read_exception_type_out), 32'(q[rdn].exc));
    end
    if (n != 0 && q[0].done) begin
      chk("commit_pc", bus.commit_pc_out, q[0].pc);
      chk("commit_data", bus.commit_reg_write_data_out, q[0].data);
      chk("commit_exc", 32'(bus.commit_exception_type_out), 32'(q[0].exc));
      chk("commit_rwa", 32'(bus.commit_reg_write_addr_out), 32'(q[0].rwa));
      chk("commit_rwe", 32'(bus.commit_reg_write_en_out), 32'(q[0].rwe));
      chk("commit_ds", 32'(bus.commit_is_delayslot_out), 32'(q[0].ds));
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
    idle();
  endtask

  initial begin
    idle();
    set_write(32'h0);
    bus.write_en = 0;
    rst = 1;
    tick();
    rst = 0;
    // reset state
    chk("rst_can_write", 32'(bus.can_write), 32'd1);
    chk("rst_can_read", 32'(bus.can_read), 32'd0);
    chk("rst_can_commit", 32'(bus.can_commit), 32'd0);
    chk("rst_wr_addr", 32'(bus.write_rob_addr_out), 32'd0);
    chk("rst_commit_pc", bus.commit_pc_out, 32'd0);

    set_write(32'hbfc00004); tick();
    chk("wr1_addr", 32'(bus.write_rob_addr_out), 32'd1);
    set_write(32'hbfc00008); tick();
    chk("wr2_addr", 32'(bus.write_rob_addr_out), 32'd2);
    chk("wr2_can_read", 32'(bus.can_read), 32'd1);
    chk("wr2_read_pc", bus.read_pc_out, 32'hbfc00004);

    bus.read_en = 1; tick();
    chk("rd_addr", 32'(bus.read_rob_addr_out), 32'd1);
    chk("rd_pc", bus.read_pc_out, 32'hbfc00008);
    set_update(4'd0); tick();
    chk("upd_can_commit", 32'(bus.can_commit), 32'd1);
    chk("upd_commit_pc", bus.commit_pc_out, 32'hbfc00004);

    // read + write + update + commit in one cycle
    bus.read_en = 1; set_write(32'hbfc00014); set_update(4'd1); bus.commit_en = 1; tick();
    chk("combo_tail", 32'(bus.write_rob_addr_out), 32'd3);
    chk("combo_rd", 32'(bus.read_rob_addr_out), 32'd2);
    chk("combo_can_commit", 32'(bus.can_commit), 32'd1);
    chk("combo_commit_pc", bus.commit_pc_out, 32'hbfc00008);

    bus.erase_en = 1; bus.erase_from_addr = 4'd1; tick();
    chk("erase_tail", 32'(bus.write_rob_addr_out), 32'd1);
    chk("erase_can_read", 32'(bus.can_read), 32'd0);
    chk("erase_can_commit", 32'(bus.can_commit), 32'd0);

    // fill to full, then an extra write must be dropped
    for (int i = 0; i < 16; i++) begin set_write(32'h1000 + 32'(i) * 4); tick(); end
    chk("full_can_write", 32'(bus.can_write), 32'd0);
    set_write(32'hdead0000); tick();
    chk("full_drop_addr", 32'(bus.write_rob_addr_out), 32'd1);
    // write alongside commit while full
    set_update(4'd1); tick();
    bus.commit_en = 1; set_write(32'h2000); tick();
    chk("full_wc_tail", 32'(bus.write_rob_addr_out), 32'd2);
    chk("full_wc_can_write", 32'(bus.can_write), 32'd0);
    for (int i = 2; i < 4; i++) begin
      set_update(4'(i)); tick();
      bus.commit_en = 1; tick();
    end
    // head=4, tail=2: address 2 and 3 are outside the live range
    bus.erase_en = 1; bus.erase_from_addr = 4'd2; tick();
    chk("erase_oob_tail", 32'(bus.write_rob_addr_out), 32'd2);
    bus.erase_en = 1; bus.erase_from_addr = 4'd3; tick();
    chk("erase_oob_can_write", 32'(bus.can_write), 32'd1);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 1) == 1) set_write($urandom);
      bus.read_en   = 1'($urandom);
      bus.commit_en = ($urandom_range(0, 2) != 0);
      if (q.size() != 0 && $urandom_range(0, 4) < 2)
        set_update(q[$urandom_range(0, q.size() - 1)].addr);
      if ($urandom_range(0, 19) == 0) begin
        bus.erase_en = 1;
        bus.erase_from_addr = 4'($urandom);
      end
      tick();
    end
    rst = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
